dac_playback: RTL and testbench
===============================

Name: dac_playback

Overview:
- Arbitrary-waveform playback engine driving a 14-bit DAC channel from sys_clk; the output-side counterpart of the ADC capture path.
- The host loads samples into an internal buffer through a write port. The UART command path drives this port after moving data into the sys_clk domain.
- A start command plays the samples out at a programmable rate: once or looped, immediately or on an external trigger edge.
- Output is offset binary, so the idle output is mid-scale.

Parameters:
- DEPTH, 1000, sample buffer depth (matches the capture record length).
- AW, 10, buffer address width.
- DW, 14, sample/DAC width.
- DIVW, 8, rate divider width.
- IDLE_CODE, 14'h2000, DAC code driven when not playing (mid-scale).

Ports:
- sys_clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  DW  buffer write data.
- length  in  AW  number of samples to play, valid range 1..DEPTH; latched at start.
- rate_div  in  DIVW  each sample is held rate_div+1 cycles; latched at start.
- loop_en  in  1  1 = repeat continuously; latched at start.
- trig_mode  in  1  0 = play immediately, 1 = wait for an ext_trig rising edge; latched at start.
- ext_trig  in  1  external trigger, already synchronous to sys_clk.
- start  in  1  single-cycle start command.
- abort  in  1  single-cycle stop command.
- dac_data  out  DW  registered DAC output code.
- busy  out  1  high in ARM or PLAY.
- armed  out  1  high in ARM.
- done  out  1  one-cycle pulse at the end of a non-looped playback.
- err  out  1  one-cycle pulse when start is rejected because length is invalid.
- play_count  out  16  completed passes since the last accepted start, saturating.

Behaviour:
- Reset values:
  - dac_data = IDLE_CODE.
  - busy, armed, done, err = 0.
  - play_count = 0.
  - State = IDLE.
  - Trigger-history register = 1, so a high ext_trig at reset release is not taken as an edge.
  - Buffer contents are not cleared.
- States:
  - IDLE: waiting for start.
  - ARM: waiting for a trigger edge.
  - PLAY: streaming samples.
- Transitions:
  - IDLE -> start with length in 1..DEPTH: latch controls, clear play_count, then go to PLAY (trig_mode 0) or ARM (trig_mode 1).
  - IDLE -> start with length 0 or length > DEPTH: err pulses the next cycle; stay in IDLE.
  - start in ARM or PLAY is ignored.
  - ARM -> PLAY on the cycle a rising edge is detected (ext_trig = 1 and previous sample = 0).
  - PLAY -> IDLE after the last sample's hold period, when loop_en is 0.
  - Any state -> IDLE on abort.
- Priority: abort wins over start and over end-of-play in the same cycle.
  - On abort, dac_data returns to IDLE_CODE on the next edge.
  - No done pulse is generated on abort.
  - play_count keeps its value.
- Latency: the first sample appears on dac_data 2 cycles after start is sampled (trig_mode 0) or 2 cycles after the edge cycle (trig_mode 1). This comprises one cycle of buffer read plus one output register.
- Timing during PLAY:
  - Each sample is held exactly rate_div+1 cycles.
  - Samples play at addresses 0..length-1, with no gaps between them.
- End of pass:
  - play_count increments, saturating at 16'hFFFF.
  - loop_en 1: the next sample is address 0 with no gap.
  - loop_en 0: in the cycle after the last hold completes, dac_data = IDLE_CODE, done = 1 for that cycle, and busy falls in the same cycle.
- Writes:
  - Accepted in every state; a write with wr_addr >= DEPTH is dropped.
  - Writing the address being read in the same cycle returns the old data. New data is used on the next read of that address.
- Width rules:
  - The hold counter is DIVW wide.
  - The address counter is AW wide and compared against the latched length-1.
  - No wrap occurs past DEPTH-1.
- rst mid-playback takes effect on the next edge with the reset values above.

Decomposition:
- Package dac_pkg holds:
  - state enum {IDLE, ARM, PLAY};
  - IDLE_CODE, DEPTH, AW and DW constants.
- Sub-module wave_ram: simple dual-port, DEPTH x DW, one write port, registered read port with 1-cycle latency, inferable as M10K.

Test Plan:
- Load 0..9 with 100+i; start with length 10, rate_div 0, loop 0, trig_mode 0 at cycle T:
  - dac_data = 100..109 on cycles T+2..T+11;
  - IDLE_CODE and done = 1 at T+12;
  - play_count = 1.
- length 3, rate_div 2, loop 1: each of the 3 samples is held 3 cycles and the pattern repeats. After 4 passes, play_count = 4 and busy stays high. abort then gives IDLE_CODE on the next cycle with no done pulse.
- trig_mode 1, ext_trig held high through start: armed = 1 and dac_data stays at IDLE_CODE. Drop then raise ext_trig at edge cycle E: first sample at E+2.
- start with length 0, then with length 1001: err pulses for each, busy stays 0, dac_data = IDLE_CODE.
- During a looped 4-sample play, overwrite address 2 while it is being read: the current pass outputs the old value and the next pass outputs the new value. A write to address 1000 is dropped (reading address 1000 neighbourhood 999 is unchanged).
- Assert start and abort together in IDLE: stays IDLE. Assert rst mid-PLAY: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants and state type for the arbitrary-waveform playback engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: buffer geometry (DEPTH, AW), sample width (DW), rate divider
// width (DIVW), mid-scale idle code and the playback state enum.
package dac_pkg;

  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int DW    = 14;
  localparam int DIVW  = 8;

  // Offset-binary mid-scale: the DAC sits here whenever nothing is playing.
  localparam logic [DW-1:0] IDLE_CODE = 14'h2000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/wave_ram.sv
// Sample buffer: simple dual-port RAM, one write port, one registered read port.
// Latency: read data valid one clk edge after rd_addr is presented.
// Backpressure: none; out-of-range writes are silently dropped.
//
// Ports:
//   clk              sole clock
//   wr_en/addr/data  write port (wr_addr >= DEPTH ignored)
//   rd_addr/rd_data  read port; a same-cycle write to rd_addr returns old data
module wave_ram #(
  parameter int DEPTH = dac_pkg::DEPTH,
  parameter int AW    = dac_pkg::AW,
  parameter int DW    = dac_pkg::DW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write and read share one block so the read sees the pre-write contents
  // (read-old-data), which is the mode block RAMs provide natively.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dac_playback.sv
// Arbitrary-waveform playback: streams buffered samples to a 14-bit DAC, once or looped.
// Latency: first sample on dac_data 2 cycles after start (or after the trigger edge cycle).
// Backpressure: none; start while busy is ignored, abort always wins and idles the DAC next edge.
//
// Ports:
//   sys_clk, rst                       clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data            host buffer write port (any state)
//   length, rate_div, loop_en,
//   trig_mode                          playback controls, latched on an accepted start
//   ext_trig                           external trigger (already in sys_clk domain)
//   start, abort                       single-cycle commands
//   dac_data                           registered DAC code, IDLE_CODE when not playing
//   busy, armed                        status: ARM or PLAY / ARM only
//   done, err                          pulses: non-looped pass complete / start rejected
//   play_count                         completed passes since last accepted start (saturating)
module dac_playback
  import dac_pkg::*;
#(
  parameter int              DEPTH     = dac_pkg::DEPTH,
  parameter int              AW        = dac_pkg::AW,
  parameter int              DW        = dac_pkg::DW,
  parameter int              DIVW      = dac_pkg::DIVW,
  parameter logic [DW-1:0]   IDLE_CODE = dac_pkg::IDLE_CODE
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [AW-1:0]   length,
  input  logic [DIVW-1:0] rate_div,
  input  logic            loop_en,
  input  logic            trig_mode,
  input  logic            ext_trig,
  input  logic            start,
  input  logic            abort,
  output logic [DW-1:0]   dac_data,
  output logic            busy,
  output logic            armed,
  output logic            done,
  output logic            err,
  output logic [15:0]     play_count
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t state, state_nxt;

  // Controls latched on an accepted start.
  logic [AW-1:0]   len_m1_q;
  logic [DIVW-1:0] rate_q;
  logic            loop_q;

  // Fetch side: address/hold counters that drive the RAM read port.
  logic [AW-1:0]   addr_q;
  logic [DIVW-1:0] hold_q;
  logic            fetch_done_q;

  // Two-stage tags that travel alongside each fetched sample so that
  // pass-end/done/busy line up with what is actually on dac_data.
  logic            rd_vld_q, rd_pe_q, rd_last_q;
  logic            out_pe_q, out_last_q;

  logic            trig_q;
  logic [DW-1:0]   ram_rd_data;

  logic            len_ok, trig_edge, fetch_vld, hold_end, pass_end;
  logic            accept, reject;

  assign len_ok    = (length != '0) && (32'(length) <= 32'(DEPTH));
  assign trig_edge = ext_trig & ~trig_q;
  assign fetch_vld = (state == PLAY) && !fetch_done_q;
  assign hold_end  = (hold_q == rate_q);
  assign pass_end  = fetch_vld && hold_end && (addr_q == len_m1_q);

  wave_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_wave_ram (
    .clk     (sys_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr_q),
    .rd_data (ram_rd_data)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              accept    = 1'b1;
              state_nxt = trig_mode ? ARM : PLAY;
            end else begin
              reject = 1'b1;
            end
          end
        end
        ARM: begin
          if (trig_edge) state_nxt = PLAY;
        end
        PLAY: begin
          // Leave only once the final sample has finished on the output.
          if (out_last_q) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign armed = (state == ARM);

  // ------------------------------------------------------------ datapath
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      len_m1_q     <= '0;
      rate_q       <= '0;
      loop_q       <= 1'b0;
      addr_q       <= '0;
      hold_q       <= '0;
      fetch_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_pe_q      <= 1'b0;
      rd_last_q    <= 1'b0;
      out_pe_q     <= 1'b0;
      out_last_q   <= 1'b0;
      trig_q       <= 1'b1;
      dac_data     <= IDLE_CODE;
      done         <= 1'b0;
      err          <= 1'b0;
      play_count   <= '0;
    end else begin
      trig_q <= ext_trig;
      err    <= reject;
      done   <= out_last_q && !abort;

      // Counters park at the start of the buffer outside PLAY, so the first
      // PLAY cycle already fetches address 0.
      if (state != PLAY) begin
        addr_q       <= '0;
        hold_q       <= '0;
        fetch_done_q <= 1'b0;
      end else if (fetch_vld) begin
        if (hold_end) begin
          hold_q <= '0;
          if (addr_q == len_m1_q) begin
            addr_q       <= '0;
            fetch_done_q <= !loop_q;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end

      // abort flushes everything in flight so the DAC idles on the next edge.
      rd_vld_q   <= fetch_vld && !abort;
      rd_pe_q    <= pass_end && !abort;
      rd_last_q  <= pass_end && !loop_q && !abort;
      out_pe_q   <= rd_pe_q && !abort;
      out_last_q <= rd_last_q && !abort;
      dac_data   <= (rd_vld_q && !abort) ? ram_rd_data : IDLE_CODE;

      if (out_pe_q && !abort && (play_count != CNT_MAX)) begin
        play_count <= play_count + 16'd1;
      end

      // Accept only happens in IDLE with nothing in flight, so it never
      // collides with a pass-end increment.
      if (accept) begin
        len_m1_q   <= length - 1'b1;
        rate_q     <= rate_div;
        loop_q     <= loop_en;
        play_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dac_playback.sv
module tb_dac_playback;

  localparam int          DEPTH = 1000;
  localparam int          IDLE  = 'h2000;

  logic        sys_clk;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [13:0] wr_data;
  logic [9:0]  length;
  logic [7:0]  rate_div;
  logic        loop_en;
  logic        trig_mode;
  logic        ext_trig;
  logic        start;
  logic        abort;
  logic [13:0] dac_data;
  logic        busy;
  logic        armed;
  logic        done;
  logic        err;
  logic [15:0] play_count;

  dac_playback dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .length     (length),
    .rate_div   (rate_div),
    .loop_en    (loop_en),
    .trig_mode  (trig_mode),
    .ext_trig   (ext_trig),
    .start      (start),
    .abort      (abort),
    .dac_data   (dac_data),
    .busy       (busy),
    .armed      (armed),
    .done       (done),
    .err        (err),
    .play_count (play_count)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ------------------------------------------------------------------
  // Reference model. Playback is described by its start edge t0 and the
  // phase p = cycle - t0: sample index (p-2)/(rate+1) mod length is on the
  // output for p >= 2, a non-looped play ends at p = length*(rate+1)+2,
  // and completed passes = (p-2) / (length*(rate+1)).
  // The value shown at edge n was read from the buffer at edge n-1 before
  // that edge's write, so it is captured one edge ahead.
  // ------------------------------------------------------------------
  logic [13:0] ref_mem [DEPTH];
  int  m_mode = 0;          // 0 idle, 1 armed, 2 playing
  int  t0, m_len, m_rate, per, p, k;
  bit  m_loop;
  bit  trig_prev = 1'b1;
  int  exp_cnt = 0, exp_dac = IDLE;
  bit  exp_done, exp_err;
  int  cap_val = 0;

  always @(posedge sys_clk) begin
    cyc++;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (rst) begin
      m_mode    = 0;
      trig_prev = 1'b1;
      exp_cnt   = 0;
    end else begin
      if (abort) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (start) begin
          if (length >= 1 && int'(length) <= DEPTH) begin
            m_len   = int'(length);
            m_rate  = int'(rate_div);
            m_loop  = loop_en;
            exp_cnt = 0;
            if (trig_mode) m_mode = 1;
            else begin
              m_mode = 2;
              t0     = cyc;
            end
          end else begin
            exp_err = 1'b1;
          end
        end
      end else if (m_mode == 1) begin
        if (ext_trig && !trig_prev) begin
          m_mode = 2;
          t0     = cyc;
        end
      end else begin
        if (!m_loop && (cyc - t0 == m_len * (m_rate + 1) + 2)) begin
          m_mode   = 0;
          exp_done = 1'b1;
          exp_cnt  = 1;
        end
      end
      trig_prev = ext_trig;
    end

    exp_dac = IDLE;
    if (m_mode == 2) begin
      per = m_len * (m_rate + 1);
      p   = cyc - t0;
      if (p >= 2) begin
        exp_cnt = ((p - 2) / per > 65535) ? 65535 : (p - 2) / per;
        if (m_loop || (p - 2) < per) exp_dac = cap_val;
      end
      k = p - 1;
      if (k >= 0 && (m_loop || k < per)) cap_val = int'(ref_mem[(k / (m_rate + 1)) % m_len]);
    end

    if (wr_en && int'(wr_addr) < DEPTH) ref_mem[wr_addr] = wr_data;

    #1;
    chk("dac_data",   int'(dac_data),   exp_dac);
    chk("busy",       int'(busy),       int'(m_mode != 0));
    chk("armed",      int'(armed),      int'(m_mode == 1));
    chk("done",       int'(done),       int'(exp_done));
    chk("err",        int'(err),        int'(exp_err));
    chk("play_count", int'(play_count), exp_cnt);
  end

  // ------------------------------------------------------------------
  // Directed scenarios with hand-computed literals, then random traffic.
  // ------------------------------------------------------------------
  int r;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    length = '0; rate_div = '0; loop_en = 1'b0; trig_mode = 1'b0;
    ext_trig = 1'b0; start = 1'b0; abort = 1'b0;
    step(3);
    chk("rst_dac",   int'(dac_data), 'h2000);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_count", int'(play_count), 0);
    rst = 1'b0;
    step(1);

    for (int a = 0; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(a);
      wr_data = (a < 10) ? 14'(100 + a) : 14'($urandom);
      step(1);
    end
    wr_en = 1'b0;
    step(2);

    // Single pass, length 10, full rate.
    length = 10'd10; rate_div = 8'd0; loop_en = 1'b0; trig_mode = 1'b0;
    start = 1'b1; step(1); start = 1'b0;       // after edge T
    step(1);                                   // T+1
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("once_sample", int'(dac_data), 100 + i);
    end
    step(1);                                   // T+12
    chk("once_idle",  int'(dac_data), 'h2000);
    chk("once_done",  int'(done), 1);
    chk("once_busy",  int'(busy), 0);
    chk("once_count", int'(play_count), 1);

    // Looped, 3 samples held 3 cycles each (9-cycle pass).
    step(3);
    length = 10'd3; rate_div = 8'd2; loop_en = 1'b1;
    start = 1'b1; step(1); start = 1'b0;       // T
    step(4);
    chk("loop_hold0", int'(dac_data), 100);    // T+4, third cycle of sample 0
    step(1);
    chk("loop_s1",    int'(dac_data), 101);    // T+5
    step(32);
    chk("loop_cnt3",  int'(play_count), 3);    // T+37
    step(1);
    chk("loop_cnt4",  int'(play_count), 4);    // T+38
    chk("loop_busy",  int'(busy), 1);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("abort_dac",  int'(dac_data), 'h2000);
    chk("abort_done", int'(done), 0);
    chk("abort_cnt",  int'(play_count), 4);

    // Triggered start with ext_trig already high.
    step(2);
    ext_trig = 1'b1; length = 10'd3; rate_div = 8'd0; loop_en = 1'b0; trig_mode = 1'b1;
    start = 1'b1; step(1); start = 1'b0; trig_mode = 1'b0;
    step(3);
    chk("arm_armed", int'(armed), 1);
    chk("arm_dac",   int'(dac_data), 'h2000);
    ext_trig = 1'b0; step(1);
    ext_trig = 1'b1; step(1);                  // edge cycle E
    chk("trig_armed", int'(armed), 0);
    step(2);
    chk("trig_first", int'(dac_data), 100);    // E+2
    step(3);
    chk("trig_done",  int'(done), 1);          // E+5

    // Rejected lengths.
    step(2);
    length = 10'd0; start = 1'b1; step(1); start = 1'b0;
    chk("len0_err",  int'(err), 1);
    chk("len0_busy", int'(busy), 0);
    step(1);
    chk("err_pulse", int'(err), 0);
    length = 10'd1001; start = 1'b1; step(1); start = 1'b0;
    chk("len1001_err", int'(err), 1);
    chk("len1001_dac", int'(dac_data), 'h2000);

    // Overwrite address 2 on the very edge it is read.
    step(2);
    length = 10'd4; rate_div = 8'd0; loop_en = 1'b1;
    start = 1'b1; step(1); start = 1'b0;       // T
    step(2);
    wr_en = 1'b1; wr_addr = 10'd2; wr_data = 14'd777;
    step(1); wr_en = 1'b0;                     // T+3
    step(1);
    chk("rdw_old", int'(dac_data), 102);       // T+4
    step(4);
    chk("rdw_new", int'(dac_data), 777);       // T+8
    abort = 1'b1; step(1); abort = 1'b0;

    // Out-of-range write must not disturb the last address.
    wr_en = 1'b1; wr_addr = 10'd999; wr_data = 14'd555; step(1);
    wr_addr = 10'd1000; wr_data = 14'd1234; step(1);
    wr_en = 1'b0;
    length = 10'd1000; rate_div = 8'd0; loop_en = 1'b0;
    start = 1'b1; step(1); start = 1'b0;       // T
    step(1001);
    chk("addr999", int'(dac_data), 555);       // T+1001
    step(1);
    chk("full_done", int'(done), 1);

    // start and abort together in IDLE.
    step(2);
    length = 10'd5; start = 1'b1; abort = 1'b1; step(1);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", int'(busy), 0);
    chk("sa_err",  int'(err), 0);

    // Reset in the middle of a looped play.
    loop_en = 1'b1; rate_div = 8'd1; length = 10'd5;
    start = 1'b1; step(1); start = 1'b0;
    step(14);
    chk("pre_rst_cnt", int'(play_count), 1);
    rst = 1'b1; step(1);
    chk("mid_rst_dac",   int'(dac_data), 'h2000);
    chk("mid_rst_busy",  int'(busy), 0);
    chk("mid_rst_count", int'(play_count), 0);
    rst = 1'b0;
    step(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 5) == 0) ext_trig = ~ext_trig;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(990, 1023))
                                            : 10'($urandom_range(0, 15));
      wr_data = 14'($urandom);
      r = int'($urandom_range(0, 19));
      length = (r == 0) ? 10'd0 :
               (r == 1) ? 10'($urandom_range(1001, 1023)) :
                          10'($urandom_range(1, 12));
      rate_div  = 8'($urandom_range(0, 3));
      loop_en   = ($urandom_range(0, 3) == 0);
      trig_mode = ($urandom_range(0, 2) == 0);
      step(1);
    end
    start = 1'b0; abort = 1'b1; wr_en = 1'b0;
    step(1);
    abort = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
